// File: rtl/lcd12864_reader_if.sv
// lcd12864_reader_if: request/response, bus-arbitration and LCD read-bus signals of the LCD12864 reader.
interface lcd12864_reader_if;
    logic       req_valid;
    logic       req_ready;
    logic       req_kind;
    logic       req_poll;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic       rsp_timeout;
    logic       bus_req;
    logic       bus_gnt;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_en;
    logic [7:0] lcd_db_i;
    modport master (
        input  req_valid, req_kind, req_poll, rsp_ready, bus_gnt, lcd_db_i,
        output req_ready, rsp_valid, rsp_data, rsp_timeout, bus_req, lcd_rs, lcd_rw, lcd_en
    );
    modport slave (
        output req_valid, req_kind, req_poll, rsp_ready, bus_gnt, lcd_db_i,
        input  req_ready, rsp_valid, rsp_data, rsp_timeout, bus_req, lcd_rs, lcd_rw, lcd_en
    );
endinterface

// File: rtl/lcd12864_reader.sv
// lcd12864_reader: timed ST7920 status/data read master with optional BF polling.
// Macro LCD12864_DUMMY_READ_EN adds a discarded dummy read cycle before each data read.
module lcd12864_reader #(
    parameter int SETUP_CYC   = 10,
    parameter int EN_HIGH_CYC = 63,
    parameter int HOLD_CYC    = 5,
    parameter int BF_TIMEOUT  = 125000
) (
    input logic                i_sys_clk,
    input logic                i_sys_rst_n,
    lcd12864_reader_if.master  bus
);
    localparam int PH_MAX = (SETUP_CYC > EN_HIGH_CYC) ? ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC)
                                                      : ((EN_HIGH_CYC > HOLD_CYC) ? EN_HIGH_CYC : HOLD_CYC);
    localparam int PH_W = $clog2(PH_MAX + 1);
    localparam int TW   = $clog2(BF_TIMEOUT + 1);
    localparam logic [TW-1:0] T_MAX = TW'(BF_TIMEOUT);
`ifdef LCD12864_DUMMY_READ_EN
    localparam logic DUMMY = 1'b1;
`else
    localparam logic DUMMY = 1'b0;
`endif
    typedef enum logic [2:0] {IDLE, ARB, SETUP, STROBE, HOLD, CHECK, RESP} state_t;
    state_t          r_state, w_nxt;
    logic [PH_W-1:0] r_ph, w_ph;
    logic [TW-1:0]   r_tcnt;
    logic [7:0]      r_sample;
    logic            r_kind, r_poll, r_dummy, r_to;
    logic            w_acc, w_done, w_again, w_cyc;
    assign w_acc   = bus.req_valid && (r_state == IDLE);
    assign w_done  = (r_ph == '0);
    assign w_again = r_dummy || (r_poll && r_sample[7] && (r_tcnt < T_MAX));
    always_comb begin
        w_nxt = r_state;
        case (r_state)
            IDLE:    w_nxt = bus.req_valid ? ARB : IDLE;
            ARB:     w_nxt = bus.bus_gnt ? SETUP : ARB;
            SETUP:   w_nxt = w_done ? STROBE : SETUP;
            STROBE:  w_nxt = w_done ? HOLD : STROBE;
            HOLD:    w_nxt = w_done ? CHECK : HOLD;
            CHECK:   w_nxt = w_again ? SETUP : RESP;
            RESP:    w_nxt = bus.rsp_ready ? IDLE : RESP;
            default: w_nxt = IDLE;
        endcase
        // one shared down-counter, reloaded whenever a new phase begins
        w_ph = (w_nxt != r_state) ? ((w_nxt == SETUP)  ? PH_W'(SETUP_CYC - 1) :
                                     (w_nxt == STROBE) ? PH_W'(EN_HIGH_CYC - 1) :
                                     (w_nxt == HOLD)   ? PH_W'(HOLD_CYC - 1) : '0)
                                  : (w_done ? r_ph : r_ph - 1'b1);
    end
    always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
        if (!i_sys_rst_n) begin
            r_state  <= IDLE;
            r_ph     <= '0;
            r_tcnt   <= '0;
            r_sample <= '0;
            r_kind   <= 1'b0;
            r_poll   <= 1'b0;
            r_dummy  <= 1'b0;
            r_to     <= 1'b0;
        end else begin
            r_state <= w_nxt;
            r_ph    <= w_ph;
            if (w_acc) begin
                r_kind  <= bus.req_kind;
                r_poll  <= bus.req_poll & ~bus.req_kind;
                r_dummy <= DUMMY & bus.req_kind;
                r_tcnt  <= '0;
                r_to    <= 1'b0;
            end else begin
                if (r_tcnt < T_MAX) r_tcnt <= r_tcnt + 1'b1;
                if (r_state == CHECK) r_dummy <= 1'b0;
            end
            if (r_state == STROBE && w_done) r_sample <= bus.lcd_db_i;
            if (r_state == CHECK && !w_again) r_to <= r_poll && r_sample[7] && (r_tcnt >= T_MAX);
        end
    end
    assign w_cyc           = (r_state == SETUP) || (r_state == STROBE) || (r_state == HOLD) || (r_state == CHECK);
    assign bus.req_ready   = (r_state == IDLE);
    assign bus.bus_req     = w_cyc || (r_state == ARB);
    assign bus.lcd_rw      = w_cyc;
    assign bus.lcd_rs      = w_cyc && r_kind;
    assign bus.lcd_en      = (r_state == STROBE);
    assign bus.rsp_valid   = (r_state == RESP);
    assign bus.rsp_data    = r_sample;
    assign bus.rsp_timeout = r_to;
endmodule
